// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported synchronous memory between instruction fetch and load/store.
// Build option ARB_ROUND_ROBIN_EN: alternating priority on contention instead of ls priority + starve counter.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                ls_req,
   input  logic                ls_we,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic [DATA_W-1:0]   ls_wdata,
   input  logic [DATA_W/8-1:0] ls_be,
   output logic                ls_gnt,
   output logic                ls_rvalid,
   output logic [DATA_W-1:0]   ls_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam logic [1:0] ST_WAKE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]         state;
   logic [MEM_LAT-1:0] tag_valid;
   logic [MEM_LAT-1:0] tag_owner;   // 1 = load/store, 0 = fetch
   logic [MEM_LAT-1:0] tag_killed;
   logic               fetch_req;
   logic               in_flight;
   logic               rd_gnt;
   logic               ex_valid;
   logic               ex_owner;
   logic               ex_killed;

   // A flushed fetch request is stale, so it never competes for the slot.
   assign fetch_req = if_req & ~flush;
   assign in_flight = |tag_valid;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_ls;

   always_comb begin
      if_gnt = 1'b0;
      ls_gnt = 1'b0;
      if (state == ST_RUN) begin
         if (fetch_req && ls_req) begin
            if_gnt = last_ls;
            ls_gnt = ~last_ls;
         end else begin
            if_gnt = fetch_req;
            ls_gnt = ls_req;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         last_ls <= 1'b1;
      else if (state == ST_RUN && fetch_req && ls_req)
         last_ls <= ls_gnt;
   end
`else
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   logic [3:0] starve_cnt;

   always_comb begin
      if_gnt = 1'b0;
      ls_gnt = 1'b0;
      if (state == ST_RUN) begin
         if (fetch_req && ls_req) begin
            if_gnt = (starve_cnt == STARVE_LIM);
            ls_gnt = (starve_cnt != STARVE_LIM);
         end else begin
            if_gnt = fetch_req;
            ls_gnt = ls_req;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         starve_cnt <= '0;
      else if (!if_req || flush || if_gnt)
         starve_cnt <= '0;
      else if (state == ST_RUN && starve_cnt != STARVE_LIM)
         starve_cnt <= starve_cnt + 4'd1;
   end
`endif

   always_comb begin
      mem_en    = if_gnt | ls_gnt;
      mem_we    = ls_gnt & ls_we;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if (if_gnt) begin
         mem_addr = if_addr;
      end else if (ls_gnt) begin
         mem_addr  = ls_addr;
         mem_wdata = ls_wdata;
         mem_be    = ls_be;
      end
   end

   assign rd_gnt = if_gnt | (ls_gnt & ~ls_we);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_valid  <= '0;
         tag_owner  <= '0;
         tag_killed <= '0;
      end else begin
         tag_valid[0]  <= rd_gnt;
         tag_owner[0]  <= ls_gnt;
         tag_killed[0] <= 1'b0;
         for (int unsigned i = 1; i < MEM_LAT; i++) begin
            tag_valid[i]  <= tag_valid[i-1];
            tag_owner[i]  <= tag_owner[i-1];
            tag_killed[i] <= tag_killed[i-1] | (flush & ~tag_owner[i-1]);
         end
      end
   end

   // The exiting stage is killed combinationally so a flush also drops data returning this cycle.
   assign ex_valid  = tag_valid[MEM_LAT-1];
   assign ex_owner  = tag_owner[MEM_LAT-1];
   assign ex_killed = tag_killed[MEM_LAT-1];
   assign if_rvalid = ex_valid & ~ex_owner & ~ex_killed & ~flush;
   assign ls_rvalid = ex_valid & ex_owner;
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= ST_WAKE;
      else begin
         case (state)
            ST_WAKE:  state <= ST_RUN;
            ST_RUN:   if (flush) state <= ST_DRAIN;
            ST_DRAIN: if (!in_flight && !flush) state <= ST_RUN;
            default:  state <= ST_WAKE;
         endcase
      end
   end

   assign busy = reset & ((state != ST_RUN) | in_flight);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter with a small behavioural memory (MEM_LAT=2).
module tb_mem_port_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int LAT  = 2;
   localparam int SMAX = 4;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          flush = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_gnt, if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          ls_req = 1'b0;
   logic          ls_we = 1'b0;
   logic [AW-1:0] ls_addr = '0;
   logic [DW-1:0] ls_wdata = '0;
   logic [3:0]    ls_be = '0;
   logic          ls_gnt, ls_rvalid;
   logic [DW-1:0] ls_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [3:0]    mem_be;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   // Memory model: 64 words, byte-enabled writes, LAT-cycle read pipe, preloaded while reset is low.
   logic [DW-1:0] mem [0:63];
   logic [DW-1:0] rd_pipe [0:LAT-1] = '{default: '0};
   assign mem_rdata = rd_pipe[LAT-1];

   always @(posedge clk) begin
      if (!reset) begin
         mem[0]  <= 32'h00A00093;
         mem[16] <= 32'hCAFEF00D;
      end else if (mem_en && mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:2]] : '0;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      if_req = 1'b0;
      ls_req = 1'b0;
      ls_we  = 1'b0;
      flush  = 1'b0;
      repeat (n) next_cycle();
   endtask

   bit exp_ls [0:9];

   initial begin
      // reset state
      repeat (3) next_cycle();
      #3;
      check("rst_busy", busy, 0);
      check("rst_if_gnt", if_gnt, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_rvalid", if_rvalid | ls_rvalid, 0);

      // release: WAKE blocks grants for one cycle
      next_cycle(); reset = 1'b1; if_req = 1'b1; if_addr = 32'h0; #3;
      check("wake_gnt", if_gnt, 0);
      check("wake_busy", busy, 1);
      next_cycle(); #3;
      check("fetch_gnt", if_gnt, 1);
      check("fetch_en", mem_en, 1);
      check("fetch_addr", mem_addr, 32'h0);
      next_cycle(); if_req = 1'b0; #3;
      check("fetch_rv_early", if_rvalid, 0);
      next_cycle(); #3;
      check("fetch_rv", if_rvalid, 1);
      check("fetch_rdata", if_rdata, 32'h00A00093);

      // contention with both requests held
      next_cycle(); if_req = 1'b1; if_addr = 32'h0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) next_cycle();
         #3;
         exp_ls[k] = RR ? (k % 2 == 1) : (k % 5 != 4);
         check("cont_ls_gnt", ls_gnt, exp_ls[k]);
         check("cont_if_gnt", if_gnt, !exp_ls[k]);
         if (k >= LAT) begin
            check("cont_ls_rv", ls_rvalid, exp_ls[k-LAT]);
            check("cont_if_rv", if_rvalid, !exp_ls[k-LAT]);
            if (exp_ls[k-LAT]) check("cont_ls_rdata", ls_rdata, 32'hCAFEF00D);
            else               check("cont_if_rdata", if_rdata, 32'h00A00093);
         end
      end
      idle(3);

      // store: one write access, never a response
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'h12345678; ls_be = 4'hF; #3;
      check("st_gnt", ls_gnt, 1);
      check("st_we", mem_we, 1);
      check("st_addr", mem_addr, 32'h40);
      check("st_wdata", mem_wdata, 32'h12345678);
      check("st_be", mem_be, 4'hF);
      next_cycle(); ls_req = 1'b0; ls_we = 1'b0; #3;
      check("st_one_cycle", mem_we, 0);
      check("st_not_busy", busy, 0);
      repeat (3) begin
         next_cycle(); #3;
         check("st_no_rv", ls_rvalid, 0);
      end

      // fetch in flight killed by flush, then drain back to RUN
      next_cycle(); if_req = 1'b1; if_addr = 32'h80; #3;
      check("fl_if_gnt", if_gnt, 1);
      next_cycle(); flush = 1'b1; #3;
      check("fl_gnt_masked", if_gnt, 0);
      check("fl_busy", busy, 1);
      next_cycle(); flush = 1'b0; if_req = 1'b0; #3;
      check("fl_no_rv", if_rvalid, 0);
      check("fl_drain_busy", busy, 1);
      next_cycle(); if_req = 1'b1; #3;
      check("fl_drain_gnt", if_gnt, 0);
      check("fl_drain_busy2", busy, 1);
      check("fl_no_rv2", if_rvalid, 0);
      next_cycle(); #3;
      check("fl_run_gnt", if_gnt, 1);
      check("fl_run_busy", busy, 0);
      idle(3);

      // load in flight survives flush
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40; #3;
      check("ld_gnt", ls_gnt, 1);
      next_cycle(); ls_req = 1'b0; flush = 1'b1; #3;
      check("ld_busy", busy, 1);
      next_cycle(); #3;
      check("ld_rv", ls_rvalid, 1);
      check("ld_rdata", ls_rdata, 32'h12345678);
      check("ld_no_if_rv", if_rvalid, 0);
      next_cycle(); flush = 1'b0; #3;
      check("ld_rv_once", ls_rvalid, 0);
      idle(3);

      // async reset with two reads in flight
      if_req = 1'b1; if_addr = 32'h0; #3;
      check("r_if_gnt", if_gnt, 1);
      next_cycle(); if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40; #3;
      check("r_ls_gnt", ls_gnt, 1);
      next_cycle(); ls_req = 1'b0; #3;
      check("r_pre_rv", if_rvalid, 1);
      #1; reset = 1'b0; #1;
      check("r_if_rv", if_rvalid, 0);
      check("r_ls_rv", ls_rvalid, 0);
      check("r_if_rdata", if_rdata, 0);
      check("r_busy", busy, 0);
      check("r_mem_en", mem_en, 0);
      repeat (2) next_cycle();
      reset = 1'b1;
      repeat (4) begin
         next_cycle(); #3;
         check("r_post_rv", if_rvalid | ls_rvalid, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
